// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; a floor of 1 keeps the counter legal for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, valid/ready on both sides.
// Optional signed-overflow output Ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    full_subtractor_1bit u_cell (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // Control FSM plus the serial datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= A;
                        r_b_sr   <= B;
                        r_borrow <= Bin;
                        r_d_sr   <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_d_sr   <= {w_d, r_d_sr[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    // Counter parks on the last bit so it never wraps.
                    if (r_cnt == LAST_BIT) begin
                        r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= r_borrow ^ w_bo;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign D         = r_d_sr;
    assign Bout      = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 8), including backpressure,
// mid-run reset and back-to-back throughput; checks Ovf when SERIAL_SUB_OVF_EN is set.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int drive_cyc = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready_wait_timeout", 32'(in_ready), 32'd1);
        A         = a;
        B         = b;
        Bin       = bin;
        in_valid  = 1'b1;
        drive_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           prev_cyc;
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        vecs[0] = '{"sub_5_3",     8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{"sub_3_5",     8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{"sub_0_0_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{"sub_80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{"sub_7f_ff",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{"sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{"sub_00_80",   8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_D", 32'(D), 32'd0);
        check("reset_Bout", 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_Ovf", 32'(Ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(W));
            check({vecs[i].name, "_D"}, 32'(D), 32'(vecs[i].d));
            check({vecs[i].name, "_Bout"}, 32'(Bout), 32'(vecs[i].bout));
`ifdef SERIAL_SUB_OVF_EN
            check({vecs[i].name, "_Ovf"}, 32'(Ovf), 32'(vecs[i].ovf));
`endif
        end

        // Backpressure: result holds, input side stays closed
        @(negedge clk);
        out_ready = 1'b0;
        do_op(8'h5A, 8'h33, 1'b1, lat);
        check("bp_latency", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
            A        = 8'hFF;
            B        = 8'h00;
            Bin      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_D", 32'(D), 32'h26);
            check("bp_hold_Bout", 32'(Bout), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_high", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset during RUN bit 3 discards the partial result
        A        = 8'hAA;
        B        = 8'h11;
        Bin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_D", 32'(D), 32'd0);
        check("midrst_Bout", 32'(Bout), 32'd0);
        do_op(8'h10, 8'h01, 1'b0, lat);
        check("after_rst_latency", 32'(lat), 32'(W));
        check("after_rst_D", 32'(D), 32'h0F);
        check("after_rst_Bout", 32'(Bout), 32'd0);

        // Back-to-back random operations at WIDTH+2 spacing
        prev_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - (W + 1)'(rbin);
            do_op(ra, rb, rbin, lat);
            check("b2b_D", 32'(D), 32'(full[W-1:0]));
            check("b2b_Bout", 32'(Bout), 32'(full[W]));
            if (i > 0) check("b2b_spacing", 32'(drive_cyc - prev_cyc), 32'(W + 2));
            prev_cyc = drive_cyc;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
